// File: rtl/sketch_row_update_if.sv
// -----------------------------------------------------------------------------
// sketch_row_update_if
//
// Groups the request and result signals that sit between the CRC32 hash
// stage, the sketch row updater and the estimator logic.
//
//   idx_i        HW  bucket index from the hash stage
//   idx_valid_i  1   index valid
//   op_i         1   0 = update (add inc_i), 1 = query (no write)
//   inc_i        CW  increment applied by update ops
//   clr_i        1   single-cycle request to zero the whole row
//   ready_o      1   requests accepted while high
//   cnt_o        CW  resulting counter value
//   cnt_valid_o  1   cnt_o valid strobe
//   cnt_idx_o    HW  index belonging to cnt_o
//   drop_cnt_o   DW  saturating count of requests dropped while not ready
//
// master: the request producer / result consumer side.
// slave : the row updater itself.
// -----------------------------------------------------------------------------
interface sketch_row_update_if #(
    parameter int HW = 10,
    parameter int CW = 16,
    parameter int DW = 16
);
    logic [HW-1:0] idx_i;
    logic          idx_valid_i;
    logic          op_i;
    logic [CW-1:0] inc_i;
    logic          clr_i;
    logic          ready_o;
    logic [CW-1:0] cnt_o;
    logic          cnt_valid_o;
    logic [HW-1:0] cnt_idx_o;
    logic [DW-1:0] drop_cnt_o;

    modport master (
        output idx_i,
        output idx_valid_i,
        output op_i,
        output inc_i,
        output clr_i,
        input  ready_o,
        input  cnt_o,
        input  cnt_valid_o,
        input  cnt_idx_o,
        input  drop_cnt_o
    );

    modport slave (
        input  idx_i,
        input  idx_valid_i,
        input  op_i,
        input  inc_i,
        input  clr_i,
        output ready_o,
        output cnt_o,
        output cnt_valid_o,
        output cnt_idx_o,
        output drop_cnt_o
    );
endinterface

// File: rtl/sketch_row_update.sv
// -----------------------------------------------------------------------------
// sketch_row_update
//
// One row of 2^HW saturating CW-bit counters held in a synchronous-read,
// read-first block RAM. Each accepted request performs a pipelined
// read-modify-write (update) or a plain read (query); the resulting count
// is returned two cycles after acceptance. A sweeper zeroes the row after
// reset and on a clr request.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    sketch_row_update_if.slave (requests in, results and status out)
//
// State table:
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_CLEAR  | sweep writes 0 to address sweep_q each cycle, not ready
//   ST_RUN    | requests accepted, clr_i starts a drain
//   ST_DRAIN  | not ready, waiting for the pipeline to empty
// -----------------------------------------------------------------------------
module sketch_row_update #(
    parameter int HW = 10,
    parameter int CW = 16,
    parameter int DW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    sketch_row_update_if.slave bus
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int            DEPTH     = 1 << HW;
    localparam logic [HW-1:0] LAST_ADDR = '1;
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [DW-1:0] DROP_MAX  = '1;

    // FSM and sweeper
    state_t        state_q, state_d;
    logic [HW-1:0] sweep_q, sweep_d;
    logic          enter_run;

    // S1: accepted request, RAM read in flight
    logic          s1_valid_q, s1_valid_d;
    logic [HW-1:0] s1_idx_q,   s1_idx_d;
    logic          s1_op_q,    s1_op_d;
    logic [CW-1:0] s1_inc_q,   s1_inc_d;

    // S2: computed result waiting for the output register
    logic          s2_valid_q, s2_valid_d;
    logic [HW-1:0] s2_idx_q,   s2_idx_d;
    logic [CW-1:0] s2_cnt_q,   s2_cnt_d;

    // Output registers
    logic          cnt_valid_q, cnt_valid_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [HW-1:0] cnt_idx_q,   cnt_idx_d;
    logic [DW-1:0] drop_q,      drop_d;

    // Most recent RAM write, covers the read-first hazard at distance 1
    logic          fwd_valid_q, fwd_valid_d;
    logic [HW-1:0] fwd_addr_q,  fwd_addr_d;
    logic [CW-1:0] fwd_data_q,  fwd_data_d;

    // RAM
    logic [CW-1:0] mem [0:DEPTH-1];
    logic [CW-1:0] ram_rdata_q;
    logic          ram_we;
    logic [HW-1:0] ram_waddr;
    logic [CW-1:0] ram_wdata;

    // Datapath intermediates
    logic          ready;
    logic          accept;
    logic [CW-1:0] base_val;
    logic [CW:0]   sum_val;
    logic [CW-1:0] upd_val;
    logic [CW-1:0] new_val;

    assign ready  = (state_q == ST_RUN);
    assign accept = bus.idx_valid_i & ready;

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        enter_run = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (sweep_q == LAST_ADDR) begin
                    state_d   = ST_RUN;
                    sweep_d   = '0;
                    enter_run = 1'b1;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.clr_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The sweep must not race a pending pipeline write.
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Read-modify-write datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // The RAM read issued on the accepting edge misses a write made on
        // that same edge (read-first), so the previous write is forwarded.
        base_val = ram_rdata_q;
        if (fwd_valid_q && (fwd_addr_q == s1_idx_q)) begin
            base_val = fwd_data_q;
        end

        sum_val = {1'b0, base_val} + {1'b0, s1_inc_q};
        upd_val = sum_val[CW] ? CNT_MAX : sum_val[CW-1:0];
        new_val = s1_op_q ? base_val : upd_val;

        // CLEAR and a live S1 never coexist: DRAIN empties the pipe first
        // and reset clears S1.
        ram_we    = 1'b0;
        ram_waddr = s1_idx_q;
        ram_wdata = new_val;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = sweep_q;
            ram_wdata = '0;
        end else if (s1_valid_q && !s1_op_q) begin
            ram_we = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = accept;
        s1_idx_d   = s1_idx_q;
        s1_op_d    = s1_op_q;
        s1_inc_d   = s1_inc_q;
        if (accept) begin
            s1_idx_d = bus.idx_i;
            s1_op_d  = bus.op_i;
            s1_inc_d = bus.inc_i;
        end

        s2_valid_d = s1_valid_q;
        s2_idx_d   = s2_idx_q;
        s2_cnt_d   = s2_cnt_q;
        if (s1_valid_q) begin
            s2_idx_d = s1_idx_q;
            s2_cnt_d = new_val;
        end

        cnt_valid_d = s2_valid_q;
        cnt_d       = cnt_q;
        cnt_idx_d   = cnt_idx_q;
        if (s2_valid_q) begin
            cnt_d     = s2_cnt_q;
            cnt_idx_d = s2_idx_q;
        end

        drop_d = drop_q;
        if (bus.idx_valid_i && !ready && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + 1'b1;
        end

        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        if (ram_we) begin
            fwd_valid_d = 1'b1;
            fwd_addr_d  = ram_waddr;
            fwd_data_d  = ram_wdata;
        end
        // The last sweep write is already visible to any RUN-state read.
        if (enter_run) begin
            fwd_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            sweep_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_op_q     <= 1'b0;
            s1_inc_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_idx_q    <= '0;
            s2_cnt_q    <= '0;
            cnt_valid_q <= 1'b0;
            cnt_q       <= '0;
            cnt_idx_q   <= '0;
            drop_q      <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_op_q     <= s1_op_d;
            s1_inc_q    <= s1_inc_d;
            s2_valid_q  <= s2_valid_d;
            s2_idx_q    <= s2_idx_d;
            s2_cnt_q    <= s2_cnt_d;
            cnt_valid_q <= cnt_valid_d;
            cnt_q       <= cnt_d;
            cnt_idx_q   <= cnt_idx_d;
            drop_q      <= drop_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    // Block RAM: no reset on contents, read-first on a same-address write.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_rdata_q <= mem[bus.idx_i];
    end

    assign bus.ready_o     = ready;
    assign bus.cnt_o       = cnt_q;
    assign bus.cnt_valid_o = cnt_valid_q;
    assign bus.cnt_idx_o   = cnt_idx_q;
    assign bus.drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_sketch_row_update.sv
// -----------------------------------------------------------------------------
// tb_sketch_row_update
//
// Directed bench for sketch_row_update with HW=4, CW=8, DW=16. A negedge
// monitor queues every result with the cycle it appeared on; directed
// sequences then pop and compare against hand-computed values.
// -----------------------------------------------------------------------------
module tb_sketch_row_update;

    logic clk;
    logic rst_n;

    sketch_row_update_if #(.HW(4), .CW(8), .DW(16)) bus ();

    sketch_row_update #(.HW(4), .CW(8), .DW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int idx;
        int cnt;
        int cyc;
    } out_t;

    out_t q[$];
    int   cyc;
    int   acc_cyc;
    int   n_checks;
    int   n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.cnt_valid_o === 1'b1) begin
            q.push_back('{int'(bus.cnt_idx_o), int'(bus.cnt_o), cyc});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] i, input logic op, input logic [7:0] inc);
        bus.idx_i       = i;
        bus.op_i        = op;
        bus.inc_i       = inc;
        bus.idx_valid_i = 1'b1;
        tick();
        acc_cyc         = cyc;
        bus.idx_valid_i = 1'b0;
    endtask

    task automatic flush();
        repeat (3) tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic expect_out(input string tag, input int idx, input int cnt, input int cyc_exp);
        out_t e;
        check({tag, "_present"}, int'(q.size() > 0), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check({tag, "_idx"}, e.idx, idx);
            check({tag, "_cnt"}, e.cnt, cnt);
            check({tag, "_cyc"}, e.cyc, cyc_exp);
        end
    endtask

    initial begin
        int n;
        int rc;

        n_checks        = 0;
        n_errors        = 0;
        cyc             = 0;
        acc_cyc         = 0;
        rst_n           = 1'b0;
        bus.idx_i       = '0;
        bus.idx_valid_i = 1'b0;
        bus.op_i        = 1'b0;
        bus.inc_i       = '0;
        bus.clr_i       = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_ready",     int'(bus.ready_o),     0);
        check("rst_cnt",       int'(bus.cnt_o),       0);
        check("rst_cnt_valid", int'(bus.cnt_valid_o), 0);
        check("rst_cnt_idx",   int'(bus.cnt_idx_o),   0);
        check("rst_drop",      int'(bus.drop_cnt_o),  0);

        // 1: sweep length and first query
        rst_n = 1'b1;
        wait_ready(n);
        check("t1_clear_len", n, 16);
        req(4'd5, 1'b1, 8'd0);
        rc = acc_cyc;
        flush();
        expect_out("t1_q5", 5, 0, rc + 2);

        // 2: back-to-back updates to one index
        req(4'd3, 1'b0, 8'd1);
        rc = acc_cyc;
        req(4'd3, 1'b0, 8'd1);
        req(4'd3, 1'b0, 8'd1);
        req(4'd3, 1'b0, 8'd1);
        flush();
        for (int k = 0; k < 4; k++) begin
            expect_out("t2_acc", 3, k + 1, rc + 2 + k);
        end
        req(4'd3, 1'b1, 8'd0);
        rc = acc_cyc;
        flush();
        expect_out("t2_q3", 3, 4, rc + 2);

        // 3: interleaved, distance-2 reuse
        req(4'd7, 1'b0, 8'd10);
        rc = acc_cyc;
        req(4'd9, 1'b0, 8'd20);
        req(4'd7, 1'b0, 8'd5);
        req(4'd9, 1'b1, 8'd0);
        flush();
        expect_out("t3_u7a", 7, 10, rc + 2);
        expect_out("t3_u9",  9, 20, rc + 3);
        expect_out("t3_u7b", 7, 15, rc + 4);
        expect_out("t3_q9",  9, 20, rc + 5);

        // 4: saturation, inc=0 update, end indices
        req(4'd2,  1'b0, 8'd200);
        rc = acc_cyc;
        req(4'd2,  1'b0, 8'd200);
        req(4'd2,  1'b0, 8'd1);
        req(4'd2,  1'b0, 8'd0);
        req(4'd0,  1'b0, 8'd9);
        req(4'd15, 1'b0, 8'd7);
        req(4'd15, 1'b0, 8'd0);
        req(4'd0,  1'b1, 8'd0);
        flush();
        expect_out("t4_sat_a", 2,  200, rc + 2);
        expect_out("t4_sat_b", 2,  255, rc + 3);
        expect_out("t4_sat_c", 2,  255, rc + 4);
        expect_out("t4_inc0",  2,  255, rc + 5);
        expect_out("t4_idx0",  0,  9,   rc + 6);
        expect_out("t4_idx15", 15, 7,   rc + 7);
        expect_out("t4_i15_0", 15, 7,   rc + 8);
        expect_out("t4_q0",    0,  9,   rc + 9);

        // 5: clr with a same-cycle update, drops while not ready
        bus.clr_i = 1'b1;
        req(4'd4, 1'b0, 8'd6);
        rc        = acc_cyc;
        bus.clr_i = 1'b0;
        check("t5_ready_fall", int'(bus.ready_o), 0);
        bus.idx_i       = 4'd1;
        bus.op_i        = 1'b0;
        bus.inc_i       = 8'd1;
        bus.idx_valid_i = 1'b1;
        repeat (3) tick();
        bus.idx_valid_i = 1'b0;
        wait_ready(n);
        // drain of up to 3 cycles plus the 16-cycle sweep
        check("t5_low_len", int'((n + 3 >= 18) && (n + 3 <= 19)), 1);
        check("t5_drop", int'(bus.drop_cnt_o), 3);
        expect_out("t5_clr_upd", 4, 6, rc + 2);
        req(4'd0, 1'b1, 8'd0);
        rc = acc_cyc;
        for (int i = 1; i < 16; i++) begin
            req(4'(i), 1'b1, 8'd0);
        end
        flush();
        for (int i = 0; i < 16; i++) begin
            expect_out("t5_zero", i, 0, rc + 2 + i);
        end

        // 6a: reset in the middle of the sweep (address 8)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check("t6_sweep_rst_ready", int'(bus.ready_o), 0);
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        check("t6_sweep_restart_len", n, 16);
        check("t6_drop_rst", int'(bus.drop_cnt_o), 0);

        // 6b: reset with a request in flight
        req(4'd11, 1'b0, 8'd50);
        rc = acc_cyc;
        flush();
        expect_out("t6_pre", 11, 50, rc + 2);
        q.delete();
        req(4'd11, 1'b0, 8'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_pipe_rst_valid", int'(bus.cnt_valid_o), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        wait_ready(n);
        check("t6_pipe_restart_len", n, 16);
        flush();
        check("t6_no_valid", q.size(), 0);
        req(4'd11, 1'b1, 8'd0);
        rc = acc_cyc;
        flush();
        expect_out("t6_q11", 11, 0, rc + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sketch_row_update.md
Name: sketch_row_update

Overview:
- Downstream consumer of the CRC32 hash stage in the sketch datapath.
- Takes each HW-bit bucket index, together with its valid strobe, and performs a pipelined read-modify-write on a single row of 2^HW saturating counters held in synchronous-read block RAM.
- Returns the post-update count, or the current count for queries, to the estimator logic.
- Contains a clear sweeper so the row can be zeroed after reset or on request.

Parameters:
- HW, 10, index width; row depth = 2^HW.
- CW, 16, counter width.
- DW, 16, drop-counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- idx_i  in  HW  bucket index (hash stage output).
- idx_valid_i  in  1  index valid (hash stage valid).
- op_i  in  1  0 = update (add inc_i), 1 = query (no write).
- inc_i  in  CW  increment for update ops.
- clr_i  in  1  single-cycle request to zero the whole row.
- ready_o  out  1  high when requests are accepted (RUN state).
- cnt_o  out  CW  resulting counter value.
- cnt_valid_o  out  1  cnt_o valid strobe.
- cnt_idx_o  out  HW  index belonging to cnt_o.
- drop_cnt_o  out  DW  saturating count of requests dropped while not ready.

Behaviour:

Reset:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: ready_o=0, cnt_o=0, cnt_valid_o=0, cnt_idx_o=0, drop_cnt_o=0.
- All pipeline valids and the forwarding valid clear; FSM enters CLEAR with sweep address 0.
- RAM contents are not reset; the sweep zeroes them.

FSM states CLEAR, RUN, DRAIN:
- CLEAR: writes 0 to address a each cycle, a = 0 .. 2^HW-1. After writing the last address, go to RUN on the next edge. This takes exactly 2^HW cycles; ready_o=0 throughout.
- RUN: ready_o=1. On clr_i=1, go to DRAIN. A request arriving in the same cycle as clr_i is still accepted.
- DRAIN: ready_o=0. Wait until both pipeline stages are empty (at most 2 cycles), then go to CLEAR with the sweep address reset to 0.
- clr_i is ignored outside RUN.

Request acceptance:
- Accepted when idx_valid_i=1 and ready_o=1.
- When idx_valid_i=1 and ready_o=0, the request is dropped and drop_cnt_o increments, saturating at 2^DW-1.

Pipeline (fixed latency 2, no backpressure, one request per cycle):
- S1 (edge t): register idx, op and inc; issue the RAM read at idx_i.
- S2 (edge t+1): RAM data is available.
  - Base value = forwarded value if the S2 index equals the index written on the previous edge, otherwise RAM data.
  - Update op: new = min(base + inc, 2^CW-1), computed with a CW+1-bit add and saturation. Write new to RAM.
  - Query op: new = base; no write.
- Output (edge t+2): cnt_o=new, cnt_idx_o=index, cnt_valid_o=1. cnt_valid_o is otherwise 0; cnt_o holds its last value.

RAM and forwarding:
- RAM is read-first. The forwarding register holds {addr, data, valid} of the most recent RAM write, from either an S2 update or a CLEAR sweep.
- Back-to-back updates to the same index (distance 1) must see the accumulated value.
- At distance ≥ 2, RAM data is already correct.
- The forwarding valid clears on entry to RUN.

Boundary conditions:
- A counter already at max stays at max on further updates.
- inc_i=0 update behaves like a query but still writes.
- idx 0 and idx 2^HW-1 behave identically to other indices.
- A reset asserted mid-sweep or mid-pipeline aborts all activity; the FSM restarts CLEAR from address 0 and no cnt_valid_o follows the reset.

Test Plan:
1. Reset, HW=4, CW=8: ready_o=0 for exactly 16 cycles after reset release, then 1; query idx 5 → cnt_o=0, cnt_valid_o 2 cycles after the request.
2. Four back-to-back updates to idx 3 with inc=1 → cnt_o sequence 1,2,3,4 on consecutive cycles; a later query of idx 3 → 4.
3. Interleaved updates idx 7, 9, 7 with inc 10, 20, 5 → outputs 10, 20, 15 (distance-2 case); a query of idx 9 → 20.
4. Update idx 2 inc=200 twice with CW=8 → 200 then 255; a third update inc=1 → 255.
5. clr_i in RUN with an update in the same cycle: that update completes (cnt_valid_o=1); ready_o falls, the sweep runs 16 cycles, and every idx then queries 0. Three requests sent while ready_o=0 → drop_cnt_o=3.
6. rst_n pulsed mid-sweep at address 8 and again mid-pipeline: no cnt_valid_o after reset; the sweep restarts from 0 and takes the full 16 cycles.
